// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter:
// requester ids, default payload width and the output-register state.
package mux_rr_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Plain 2:1 data selector: sel=0 passes a, sel=1 passes b.
module mux_rr_arbiter_mux #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] data
);

    always_comb begin
        data = sel ? b : a;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-input round-robin arbiter feeding a single registered output slot
// with valid/ready handshakes on both sides.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    out_state_t       state;
    logic             ptr;
    logic             grant;
    logic             has_grant;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;

    always_comb begin
        has_grant = a_valid || b_valid;
        grant     = ptr;
        if (a_valid && !b_valid) begin
            grant = SRC_A;
        end else if (b_valid && !a_valid) begin
            grant = SRC_B;
        end
    end

    // reset_n gating keeps both readies low while reset is held, even between edges
    assign a_ready = reset_n && load_en && has_grant && (grant == SRC_A);
    assign b_ready = reset_n && load_en && has_grant && (grant == SRC_B);
    assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);

    mux_rr_arbiter_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a    (a_data),
        .b    (b_data),
        .sel  (grant),
        .data (sel_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= SRC_A;
            ptr      <= SRC_A;
        end else begin
            if (xfer) begin
                state    <= FULL;
                out_data <= sel_data;
                out_src  <= grant;
                ptr      <= ~grant;
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
